i2c_slave: RTL

I2C target (responder) giving the ZXUNO core an 8-byte register bank that an external I2C controller can read and write, for example a companion MCU or the test rig. It is the far end of the bit-banged I2C master on the same ZXUNO register port. The bank is also visible to the Z80 through two ZXUNO registers. SCL is input-only, so there is no clock stretching. SDA is open-drain.

---
 rtl/i2c_slave_pkg.sv | 11 +
 rtl/i2c_slave_sync.sv | 76 +++++++
 rtl/i2c_slave.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C target: ZXUNO register indices and pointer helper.
package i2c_slave_pkg;

  localparam logic [7:0] I2CSLVPTR  = 8'hA4;
  localparam logic [7:0] I2CSLVDATA = 8'hA5;

  function automatic logic [2:0] ptr_next(input logic [2:0] p);
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/i2c_slave_sync.sv
// SCL/SDA synchroniser with optional 3-sample majority filter (I2C_SLAVE_GLITCH_FILTER_EN),
// followed by edge and START/STOP detection.
module i2c_slave_sync
  import i2c_slave_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] r_scl_sync, r_sda_sync;
  logic       r_scl_d, r_sda_d;

  // Flops preset to 1 so the idle bus produces no edges when reset releases
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl};
      r_sda_sync <= {r_sda_sync[0], sda};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] r_scl_hist, r_sda_hist;
  logic       r_scl_f, r_sda_f;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_hist <= 3'b111;
      r_sda_hist <= 3'b111;
      r_scl_f    <= 1'b1;
      r_sda_f    <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[1]};
      r_scl_f    <= maj3(r_scl_hist);
      r_sda_f    <= maj3(r_sda_hist);
    end
  end

  assign scl_s = r_scl_f;
  assign sda_s = r_sda_f;
`else
  assign scl_s = r_scl_sync[1];
  assign sda_s = r_sda_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= scl_s;
      r_sda_d <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~r_scl_d;
  assign scl_fall = ~scl_s & r_scl_d;
  assign start    = scl_s & r_scl_d & r_sda_d & ~sda_s;
  assign stop     = scl_s & r_scl_d & ~r_sda_d & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target exposing an 8-byte register bank to an external controller and to the Z80
// via ZXUNO registers. Optional input glitch filter: I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe,
  input  logic       scl,
  inout  logic       sda
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WPTR, ST_WDATA,
    ST_W_ACK, ST_RDATA, ST_R_ACK, ST_IGNORE
  } state_t;

  state_t     r_state;
  logic [7:0] r_regs [0:7];
  logic [7:0] r_shift;
  logic [3:0] r_bitcnt;
  logic [2:0] r_i2c_ptr, r_cpu_ptr;
  logic       r_rw, r_sda_lo;

  logic w_unused_scl_s, w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;

  i2c_slave_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda      (sda),
    .scl_s    (w_unused_scl_s),
    .sda_s    (w_sda_s),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall),
    .start    (w_start),
    .stop     (w_stop)
  );

  assign w_byte = {r_shift[6:0], w_sda_s};
  assign sda    = r_sda_lo ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= 8'h00;
      r_bitcnt  <= 4'd0;
      r_i2c_ptr <= 3'd0;
      r_cpu_ptr <= 3'd0;
      r_rw      <= 1'b0;
      r_sda_lo  <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= 8'h00;
    end else begin
      if (w_stop) begin
        r_state  <= ST_IDLE;
        r_sda_lo <= 1'b0;
      end else if (w_start) begin
        r_state  <= ST_ADDR;
        r_bitcnt <= 4'd0;
        r_sda_lo <= 1'b0;
      end else begin
        unique case (r_state)
          ST_ADDR: if (w_scl_rise) begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              r_rw    <= w_sda_s;
              r_state <= (r_shift[6:0] == I2C_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
            end
          end
          // First SCL fall pulls SDA low for the ACK clock, the second ends it
          ST_ADDR_ACK, ST_W_ACK: if (w_scl_fall) begin
            if (!r_sda_lo) begin
              r_sda_lo <= 1'b1;
            end else begin
              r_bitcnt <= 4'd0;
              if (r_state == ST_W_ACK) begin
                r_sda_lo <= 1'b0;
                r_state  <= ST_WDATA;
              end else if (!r_rw) begin
                r_sda_lo <= 1'b0;
                r_state  <= ST_WPTR;
              end else begin
                r_shift  <= r_regs[r_i2c_ptr];
                r_sda_lo <= ~r_regs[r_i2c_ptr][7];
                r_state  <= ST_RDATA;
              end
            end
          end
          ST_WPTR, ST_WDATA: if (w_scl_rise) begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              r_state <= ST_W_ACK;
              if (r_state == ST_WPTR) begin
                r_i2c_ptr <= w_byte[2:0];
              end else begin
                r_regs[r_i2c_ptr] <= w_byte;
                r_i2c_ptr         <= ptr_next(r_i2c_ptr);
              end
            end
          end
          ST_RDATA: begin
            if (w_scl_rise) begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bitcnt == 4'd8) begin
                r_sda_lo <= 1'b0;
                r_state  <= ST_R_ACK;
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_lo <= ~r_shift[6];
              end
            end
          end
          // bitcnt 9 marks an ACK already seen; the next byte starts on the following fall
          ST_R_ACK: begin
            if (w_scl_rise) begin
              r_i2c_ptr <= ptr_next(r_i2c_ptr);
              if (w_sda_s) r_state  <= ST_IGNORE;
              else         r_bitcnt <= 4'd9;
            end else if (w_scl_fall && r_bitcnt == 4'd9) begin
              r_shift  <= r_regs[r_i2c_ptr];
              r_sda_lo <= ~r_regs[r_i2c_ptr][7];
              r_bitcnt <= 4'd0;
              r_state  <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end

      // CPU side is written last so it wins a same-cycle collision on a register
      if (zxuno_regwr && zxuno_addr == I2CSLVPTR)  r_cpu_ptr         <= din[2:0];
      if (zxuno_regwr && zxuno_addr == I2CSLVDATA) r_regs[r_cpu_ptr] <= din;
    end
  end

  always_comb begin
    oe   = 1'b0;
    dout = 8'h00;
    if (zxuno_regrd && zxuno_addr == I2CSLVPTR) begin
      oe   = 1'b1;
      dout = {5'b0, r_cpu_ptr};
    end else if (zxuno_regrd && zxuno_addr == I2CSLVDATA) begin
      oe   = 1'b1;
      dout = r_regs[r_cpu_ptr];
    end
  end

endmodule
